// File: rtl/laoc_ram_pkg.sv
// Shared definitions for the 32x8 RAM lab blocks (switch writer and scan reader).
// Contents:
//   ADDR_W_DEFAULT / DATA_W_DEFAULT  default RAM geometry
//   scan_state_t                     scan reader FSM encoding (IDLE=0, ISSUE=1, WAIT=2, SHOW=3)
//   count_width()                    width of a down-counter that must hold max_count-1
package laoc_ram_pkg;

    localparam int ADDR_W_DEFAULT = 5;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHOW  = 2'd3
    } scan_state_t;

    // A counter loaded with max_count-1 and run down to zero needs clog2(max_count)
    // bits, but never fewer than one so the declaration stays legal for max_count=1.
    function automatic int count_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pushbutton/switch input, with a
// rising-edge detector on the synchronized level.
// Ports:
//   clk       in  system clock, rising edge
//   reset     in  synchronous, active-high; clears all three flops
//   async_in  in  raw asynchronous input
//   level     out synchronized level (two clocks behind async_in)
//   rise      out one-cycle pulse in the cycle that level first reads 1
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    // meta may go metastable; sync is the first flop safe to use. sync_d holds the
    // previous synchronized value so a rising edge can be spotted combinationally,
    // keeping the pulse aligned with the first cycle that level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_d;

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side companion to the switch-driven RAM writer. Sweeps the RAM read port one
// word at a time and holds each address/data pair for the HEX display decoders.
// Auto-advances with a fixed dwell per word while run is high, or advances one word
// per step press.
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous, active-high
//   run         in   async level, 1 = auto-advance
//   step        in   async, each rising edge advances one word
//   mem_q       in   RAM read data
//   mem_addr    out  registered RAM address, stable from ISSUE until capture
//   mem_rden    out  RAM read enable, high in ISSUE and WAIT
//   disp_addr   out  address of the displayed word
//   disp_data   out  displayed word
//   disp_valid  out  set by the first capture, cleared only by reset
//   wrap        out  one-cycle pulse when the sweep pointer wraps LAST_ADDR -> 0
//   busy        out  high in ISSUE or WAIT
module ram_scan_reader
    import laoc_ram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int LAST_ADDR = 2**ADDR_W - 1,
    parameter int READ_LAT  = 1,
    parameter int DWELL     = 25_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap,
    output logic              busy
);

    localparam int LAT_W = count_width(READ_LAT);
    localparam int DW_W  = count_width(DWELL);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    scan_state_t       state;
    scan_state_t       state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DW_W-1:0]   dwell;

    logic run_s;
    logic step_pulse;
    logic run_rise_unused;
    logic step_level_unused;

    logic load_addr;
    logic load_lat;
    logic dec_lat;
    logic capture;
    logic dec_dwell;

    // run is consumed as a level and step as an edge; the spare outputs of each
    // synchronizer are deliberately left unused.
    sync_edge u_run_sync (
        .clk      (CLOCK_50),
        .reset    (reset),
        .async_in (run),
        .level    (run_s),
        .rise     (run_rise_unused)
    );

    sync_edge u_step_sync (
        .clk      (CLOCK_50),
        .reset    (reset),
        .async_in (step),
        .level    (step_level_unused),
        .rise     (step_pulse)
    );

    // State register only; all decisions live in the combinational block below.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes. A step pulse in SHOW wins over run and throws
    // away whatever dwell is left. A step pulse arriving in ISSUE or WAIT is simply
    // not looked at, so it is dropped rather than queued. With run low, SHOW neither
    // counts nor leaves, which freezes the dwell counter.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        load_lat   = 1'b0;
        dec_lat    = 1'b0;
        capture    = 1'b0;
        dec_dwell  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_s || step_pulse) begin
                    state_next = ST_ISSUE;
                    load_addr  = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                load_lat   = 1'b1;
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    state_next = ST_SHOW;
                    capture    = 1'b1;
                end else begin
                    dec_lat = 1'b1;
                end
            end
            ST_SHOW: begin
                if (step_pulse) begin
                    state_next = ST_ISSUE;
                    load_addr  = 1'b1;
                end else if (run_s) begin
                    if (dwell == '0) begin
                        state_next = ST_ISSUE;
                        load_addr  = 1'b1;
                    end else begin
                        dec_dwell = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address, latency and dwell counters plus the display registers. mem_addr is
    // loaded only on entry to ISSUE so the RAM sees a stable address for the whole
    // read. The display is written only at the capture, so it keeps the previous
    // word through ISSUE/WAIT. Reset wipes everything, which also aborts a read in
    // flight before it can be captured.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mem_addr   <= '0;
            cur_addr   <= '0;
            lat_cnt    <= '0;
            dwell      <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;

            if (load_addr) begin
                mem_addr <= cur_addr;
            end

            if (load_lat) begin
                lat_cnt <= LAT_W'(READ_LAT - 1);
            end else if (dec_lat) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (capture) begin
                disp_data  <= mem_q;
                disp_addr  <= cur_addr;
                disp_valid <= 1'b1;
                dwell      <= DW_W'(DWELL - 1);
                if (cur_addr == LAST) begin
                    cur_addr <= '0;
                    wrap     <= 1'b1;
                end else begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                end
            end else if (dec_dwell) begin
                dwell <= dwell - DW_W'(1);
            end
        end
    end

    assign busy     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign mem_rden = busy;

endmodule
